hit_resolver: RTL and testbench



---
 rtl/fighter_pkg.sv | 29 ++
 rtl/hit_resolver_if.sv | 34 +++
 rtl/hit_resolver_attack_fsm.sv | 105 ++++++++++
 rtl/hit_resolver.sv | 130 +++++++++++++
 tb/tb_hit_resolver.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter encodings and default tuning constants for the resolver, sprite and HUD blocks.
// Pure declarations: no logic, no latency.
package fighter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_RECOVER = 2'b10
    } atk_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    localparam int unsigned DEF_MAX_HEALTH     = 100;
    localparam int unsigned DEF_PUNCH_DMG      = 5;
    localparam int unsigned DEF_KICK_DMG       = 8;
    localparam int unsigned DEF_ACTIVE_TICKS   = 4;
    localparam int unsigned DEF_COOLDOWN_TICKS = 6;
    localparam int unsigned DEF_HITSTUN_TICKS  = 10;

    function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? (a - b) : 7'd0;
    endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// Collision/button inputs and fighter status outputs of the hit resolver.
// master drives flags and buttons, slave (the resolver) drives status.
interface hit_resolver_if;

    logic       p1_collision;
    logic       p2_collision;
    logic       p1_punch;
    logic       p1_kick;
    logic       p2_punch;
    logic       p2_kick;
    logic [6:0] p1_health;
    logic [6:0] p2_health;
    logic [1:0] p1_attack_state;
    logic [1:0] p2_attack_state;
    logic       p1_hitstun;
    logic       p2_hitstun;
    logic       p1_hit_pulse;
    logic       p2_hit_pulse;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output p1_collision, p2_collision, p1_punch, p1_kick, p2_punch, p2_kick,
        input  p1_health, p2_health, p1_attack_state, p2_attack_state,
        input  p1_hitstun, p2_hitstun, p1_hit_pulse, p2_hit_pulse, game_over, winner
    );

    modport slave (
        input  p1_collision, p2_collision, p1_punch, p1_kick, p2_punch, p2_kick,
        output p1_health, p2_health, p1_attack_state, p2_attack_state,
        output p1_hitstun, p2_hitstun, p1_hit_pulse, p2_hit_pulse, game_over, winner
    );

endinterface

// File: rtl/hit_resolver_attack_fsm.sv
// Per-player attack phase machine: button edge detect, attack-type latch, phase counter, landed flag.
// State changes one tick after the sampled button edge; no backpressure.
module attack_fsm
    import fighter_pkg::*;
#(
    parameter int unsigned ACTIVE_TICKS   = DEF_ACTIVE_TICKS,
    parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
    parameter int unsigned PUNCH_DMG      = DEF_PUNCH_DMG,
    parameter int unsigned KICK_DMG       = DEF_KICK_DMG
) (
    input  logic       CLK_20Hz,
    input  logic       reset,
    input  logic       punch_i,
    input  logic       kick_i,
    input  logic       start_en_i,
    input  logic       force_recover_i,
    input  logic       hold_idle_i,
    input  logic       land_i,
    output atk_state_e state_o,
    output logic [6:0] dmg_o,
    output logic       landed_o
);

    localparam logic [3:0] ACT_LOAD  = 4'(ACTIVE_TICKS - 1);
    localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_TICKS - 1);

    atk_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       punch_prev_q, kick_prev_q;
    logic       is_kick_q, is_kick_d;
    logic       landed_q, landed_d;
    logic       punch_edge, kick_edge;

    assign punch_edge = punch_i & ~punch_prev_q;
    assign kick_edge  = kick_i & ~kick_prev_q;

    always_ff @(posedge CLK_20Hz) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            punch_prev_q <= 1'b0;
            kick_prev_q  <= 1'b0;
            is_kick_q    <= 1'b0;
            landed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            punch_prev_q <= punch_i;
            kick_prev_q  <= kick_i;
            is_kick_q    <= is_kick_d;
            landed_q     <= landed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_kick_d = is_kick_q;
        landed_d  = landed_q | land_i;
        if (hold_idle_i) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            landed_d = 1'b0;
        end else if (force_recover_i && state_q != ST_IDLE) begin
            // Being hit cuts the attack short and restarts a full recovery.
            state_d = ST_RECOVER;
            cnt_d   = COOL_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_en_i && (punch_edge || kick_edge)) begin
                        state_d   = ST_ACTIVE;
                        cnt_d     = ACT_LOAD;
                        is_kick_d = kick_edge;
                        landed_d  = 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_RECOVER;
                        cnt_d   = COOL_LOAD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign state_o  = state_q;
    assign dmg_o    = is_kick_q ? 7'(KICK_DMG) : 7'(PUNCH_DMG);
    assign landed_o = landed_q;

endmodule

// File: rtl/hit_resolver.sv
// Resolves collisions and attack phases into health, hit-stun, hit pulses and KO/winner state.
// All outputs registered; a landing condition at edge j is visible after edge j.
module hit_resolver
    import fighter_pkg::*;
#(
    parameter int unsigned MAX_HEALTH     = DEF_MAX_HEALTH,
    parameter int unsigned PUNCH_DMG      = DEF_PUNCH_DMG,
    parameter int unsigned KICK_DMG       = DEF_KICK_DMG,
    parameter int unsigned ACTIVE_TICKS   = DEF_ACTIVE_TICKS,
    parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
    parameter int unsigned HITSTUN_TICKS  = DEF_HITSTUN_TICKS
) (
    input  logic           CLK_20Hz,
    input  logic           reset,
    hit_resolver_if.slave  bus
);

    localparam logic [6:0] HEALTH_INIT  = 7'(MAX_HEALTH);
    localparam logic [3:0] HITSTUN_LOAD = 4'(HITSTUN_TICKS);

    atk_state_e p1_state, p2_state;
    logic [6:0] p1_dmg, p2_dmg;
    logic       p1_landed, p2_landed;
    logic       p1_lands, p2_lands;

    logic [6:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
    logic [3:0] p1_stun_cnt_q, p1_stun_cnt_d, p2_stun_cnt_q, p2_stun_cnt_d;
    logic       p1_hitstun_q, p1_hitstun_d, p2_hitstun_q, p2_hitstun_d;
    logic       p1_pulse_q, p1_pulse_d, p2_pulse_q, p2_pulse_d;
    logic       game_over_q, game_over_d;
    winner_e    winner_q, winner_d;
    logic       p1_ko, p2_ko;

    // pN_lands: player N lands its attack on the opponent this tick.
    assign p1_lands = (p1_state == ST_ACTIVE) && !p1_landed && bus.p2_collision
                      && !p2_hitstun_q && !game_over_q;
    assign p2_lands = (p2_state == ST_ACTIVE) && !p2_landed && bus.p1_collision
                      && !p1_hitstun_q && !game_over_q;

    attack_fsm #(
        .ACTIVE_TICKS(ACTIVE_TICKS), .COOLDOWN_TICKS(COOLDOWN_TICKS),
        .PUNCH_DMG(PUNCH_DMG), .KICK_DMG(KICK_DMG)
    ) u_p1_fsm (
        .CLK_20Hz(CLK_20Hz), .reset(reset),
        .punch_i(bus.p1_punch), .kick_i(bus.p1_kick),
        .start_en_i(!p1_hitstun_q && !game_over_q),
        .force_recover_i(p2_lands), .hold_idle_i(game_over_q), .land_i(p1_lands),
        .state_o(p1_state), .dmg_o(p1_dmg), .landed_o(p1_landed)
    );

    attack_fsm #(
        .ACTIVE_TICKS(ACTIVE_TICKS), .COOLDOWN_TICKS(COOLDOWN_TICKS),
        .PUNCH_DMG(PUNCH_DMG), .KICK_DMG(KICK_DMG)
    ) u_p2_fsm (
        .CLK_20Hz(CLK_20Hz), .reset(reset),
        .punch_i(bus.p2_punch), .kick_i(bus.p2_kick),
        .start_en_i(!p2_hitstun_q && !game_over_q),
        .force_recover_i(p1_lands), .hold_idle_i(game_over_q), .land_i(p2_lands),
        .state_o(p2_state), .dmg_o(p2_dmg), .landed_o(p2_landed)
    );

    always_ff @(posedge CLK_20Hz) begin
        if (!reset) begin
            p1_health_q   <= HEALTH_INIT;
            p2_health_q   <= HEALTH_INIT;
            p1_stun_cnt_q <= 4'd0;
            p2_stun_cnt_q <= 4'd0;
            p1_hitstun_q  <= 1'b0;
            p2_hitstun_q  <= 1'b0;
            p1_pulse_q    <= 1'b0;
            p2_pulse_q    <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= WIN_NONE;
        end else begin
            p1_health_q   <= p1_health_d;
            p2_health_q   <= p2_health_d;
            p1_stun_cnt_q <= p1_stun_cnt_d;
            p2_stun_cnt_q <= p2_stun_cnt_d;
            p1_hitstun_q  <= p1_hitstun_d;
            p2_hitstun_q  <= p2_hitstun_d;
            p1_pulse_q    <= p1_pulse_d;
            p2_pulse_q    <= p2_pulse_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    always_comb begin
        p1_health_d   = p1_health_q;
        p2_health_d   = p2_health_q;
        p1_stun_cnt_d = 4'd0;
        p2_stun_cnt_d = 4'd0;
        p1_pulse_d    = 1'b0;
        p2_pulse_d    = 1'b0;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        p1_ko         = 1'b0;
        p2_ko         = 1'b0;
        if (!game_over_q) begin
            p1_pulse_d    = p2_lands;
            p2_pulse_d    = p1_lands;
            p1_stun_cnt_d = p2_lands ? HITSTUN_LOAD
                          : (p1_stun_cnt_q != 4'd0) ? p1_stun_cnt_q - 4'd1 : 4'd0;
            p2_stun_cnt_d = p1_lands ? HITSTUN_LOAD
                          : (p2_stun_cnt_q != 4'd0) ? p2_stun_cnt_q - 4'd1 : 4'd0;
            if (p2_lands) p1_health_d = sat_sub(p1_health_q, p2_dmg);
            if (p1_lands) p2_health_d = sat_sub(p2_health_q, p1_dmg);
            p1_ko = (p1_health_d == 7'd0);
            p2_ko = (p2_health_d == 7'd0);
            if (p1_ko || p2_ko) begin
                game_over_d = 1'b1;
                winner_d    = (p1_ko && p2_ko) ? WIN_DRAW : (p1_ko ? WIN_P2 : WIN_P1);
            end
        end
        p1_hitstun_d = (p1_stun_cnt_d != 4'd0);
        p2_hitstun_d = (p2_stun_cnt_d != 4'd0);
    end

    assign bus.p1_health       = p1_health_q;
    assign bus.p2_health       = p2_health_q;
    assign bus.p1_attack_state = p1_state;
    assign bus.p2_attack_state = p2_state;
    assign bus.p1_hitstun      = p1_hitstun_q;
    assign bus.p2_hitstun      = p2_hitstun_q;
    assign bus.p1_hit_pulse    = p1_pulse_q;
    assign bus.p2_hit_pulse    = p2_pulse_q;
    assign bus.game_over       = game_over_q;
    assign bus.winner          = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed scenarios for hit_resolver; expected outputs are queued per tick and checked by a monitor.
module tb_hit_resolver;

    localparam int S_H1 = 0, S_H2 = 1, S_ST1 = 2, S_ST2 = 3, S_HS1 = 4, S_HS2 = 5;
    localparam int S_GO = 6, S_WIN = 7, S_PU2 = 8;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } chk_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    p1_pulses = 0;
    int    p2_pulses = 0;
    int    exp_p1_pulses = 0;
    int    exp_p2_pulses = 0;
    int    exp_h2 = 100;
    chk_t  chk_q[$];

    hit_resolver_if bus ();

    hit_resolver dut (
        .CLK_20Hz(clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int get_sig(input int sig);
        case (sig)
            S_H1:    return int'(bus.p1_health);
            S_H2:    return int'(bus.p2_health);
            S_ST1:   return int'(bus.p1_attack_state);
            S_ST2:   return int'(bus.p2_attack_state);
            S_HS1:   return int'(bus.p1_hitstun);
            S_HS2:   return int'(bus.p2_hitstun);
            S_GO:    return int'(bus.game_over);
            S_WIN:   return int'(bus.winner);
            S_PU2:   return int'(bus.p2_hit_pulse);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Monitor: count pulses and retire every expectation due at this tick.
    always @(negedge clk) begin
        if (bus.p1_hit_pulse) p1_pulses++;
        if (bus.p2_hit_pulse) p2_pulses++;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                check(chk_q[i].name, get_sig(chk_q[i].sig), chk_q[i].val);
                chk_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int dc, input int sig, input int val, input string name);
        chk_t c;
        c.cyc  = cyc + dc;
        c.sig  = sig;
        c.val  = val;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One P1 attack landing on P2 from idle, followed by full stun/attack recovery.
    task automatic do_hit(input bit kick);
        int dmg;
        dmg = kick ? 8 : 5;
        bus.p2_collision = 1'b1;
        if (kick) bus.p1_kick = 1'b1;
        else      bus.p1_punch = 1'b1;
        exp_h2 = (exp_h2 > dmg) ? exp_h2 - dmg : 0;
        expect_at(2, S_H2, exp_h2, "hit_p2_health");
        if (exp_h2 == 0) begin
            expect_at(2, S_GO, 1, "ko_game_over");
            expect_at(2, S_WIN, 1, "ko_winner");
        end
        exp_p2_pulses++;
        tick(1);
        bus.p1_kick  = 1'b0;
        bus.p1_punch = 1'b0;
        tick(12);
    endtask

    initial begin
        bus.p1_collision = 1'b0;
        bus.p2_collision = 1'b0;
        bus.p1_punch     = 1'b0;
        bus.p1_kick      = 1'b0;
        bus.p2_punch     = 1'b0;
        bus.p2_kick      = 1'b0;

        // Reset values, then 20 idle ticks.
        reset = 1'b0;
        tick(2);
        expect_at(0, S_H1, 100, "rst_p1_health");
        expect_at(0, S_H2, 100, "rst_p2_health");
        expect_at(0, S_GO, 0, "rst_game_over");
        expect_at(0, S_WIN, 0, "rst_winner");
        reset = 1'b1;
        tick(20);
        expect_at(0, S_H1, 100, "idle_p1_health");
        expect_at(0, S_H2, 100, "idle_p2_health");
        expect_at(0, S_ST1, 0, "idle_p1_state");
        expect_at(0, S_ST2, 0, "idle_p2_state");
        expect_at(0, S_GO, 0, "idle_game_over");
        expect_at(0, S_WIN, 0, "idle_winner");
        tick(1);

        // Held punch gives one attack: 4 ACTIVE, 6 RECOVER, then IDLE for good.
        bus.p1_punch = 1'b1;
        expect_at(1, S_ST1, 1, "hold_active_first");
        expect_at(4, S_ST1, 1, "hold_active_last");
        expect_at(5, S_ST1, 2, "hold_recover_first");
        expect_at(10, S_ST1, 2, "hold_recover_last");
        expect_at(11, S_ST1, 0, "hold_idle");
        expect_at(25, S_ST1, 0, "hold_no_retrigger");
        expect_at(25, S_H2, 100, "hold_no_damage");
        tick(30);
        bus.p1_punch = 1'b0;
        tick(2);

        // Trade: both punch on the same edge with both collision flags high.
        bus.p1_collision = 1'b1;
        bus.p2_collision = 1'b1;
        bus.p1_punch     = 1'b1;
        bus.p2_punch     = 1'b1;
        expect_at(1, S_ST1, 1, "trade_p1_active");
        expect_at(2, S_H1, 95, "trade_p1_health");
        expect_at(2, S_H2, 95, "trade_p2_health");
        expect_at(2, S_HS1, 1, "trade_p1_stun");
        expect_at(2, S_HS2, 1, "trade_p2_stun");
        expect_at(2, S_ST1, 2, "trade_p1_recover");
        expect_at(2, S_ST2, 2, "trade_p2_recover");
        expect_at(7, S_ST2, 2, "trade_recover_last");
        expect_at(8, S_ST2, 0, "trade_idle");
        expect_at(12, S_HS1, 0, "trade_stun_end");
        exp_p1_pulses++;
        exp_p2_pulses++;
        tick(1);
        bus.p1_punch = 1'b0;
        bus.p2_punch = 1'b0;
        tick(14);
        bus.p1_collision = 1'b0;
        bus.p2_collision = 1'b0;
        tick(1);

        // P1 kick into a held P2 collision: one hit of 8, 10 ticks of stun.
        bus.p2_collision = 1'b1;
        bus.p1_kick      = 1'b1;
        expect_at(1, S_H2, 95, "kick_before_land");
        expect_at(1, S_PU2, 0, "kick_pulse_pre");
        expect_at(2, S_H2, 87, "kick_p2_health");
        expect_at(2, S_PU2, 1, "kick_pulse");
        expect_at(3, S_PU2, 0, "kick_pulse_drop");
        expect_at(2, S_HS2, 1, "kick_stun_start");
        expect_at(11, S_HS2, 1, "kick_stun_last");
        expect_at(12, S_HS2, 0, "kick_stun_end");
        expect_at(4, S_H2, 87, "kick_single_land");
        expect_at(4, S_ST1, 1, "kick_still_active");
        expect_at(4, S_ST2, 0, "kick_victim_idle");
        expect_at(5, S_ST1, 2, "kick_recover");
        exp_p2_pulses++;
        tick(1);
        bus.p1_kick = 1'b0;
        tick(14);
        exp_h2 = 87;

        // Wear P2 down to 5, then a kick saturates to 0 and ends the game.
        for (int i = 0; i < 10; i++) do_hit(1'b0);
        for (int i = 0; i < 4; i++) do_hit(1'b1);
        expect_at(0, S_H2, 5, "pre_ko_health");
        tick(1);
        do_hit(1'b1);
        bus.p1_kick  = 1'b1;
        bus.p2_punch = 1'b1;
        expect_at(3, S_ST1, 0, "ko_p1_held_idle");
        expect_at(3, S_ST2, 0, "ko_p2_held_idle");
        expect_at(3, S_H2, 0, "ko_p2_frozen");
        expect_at(3, S_H1, 95, "ko_p1_frozen");
        expect_at(3, S_GO, 1, "ko_sticky");
        expect_at(3, S_WIN, 1, "ko_winner_sticky");
        expect_at(3, S_HS2, 0, "ko_stun_cleared");
        tick(5);
        bus.p1_kick  = 1'b0;
        bus.p2_punch = 1'b0;
        tick(1);

        // Reset mid-ACTIVE and mid-stun with P2 at 84.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_h2 = 100;
        expect_at(0, S_GO, 0, "rst2_game_over");
        expect_at(0, S_WIN, 0, "rst2_winner");
        tick(1);
        do_hit(1'b1);
        bus.p1_kick = 1'b1;
        expect_at(2, S_H2, 84, "mid_p2_health");
        exp_p2_pulses++;
        tick(3);
        expect_at(0, S_ST1, 1, "mid_p1_active");
        expect_at(0, S_HS2, 1, "mid_p2_stun");
        reset       = 1'b0;
        bus.p1_kick = 1'b0;
        expect_at(1, S_H2, 100, "mid_rst_health");
        expect_at(1, S_ST1, 0, "mid_rst_state");
        expect_at(1, S_HS2, 0, "mid_rst_stun");
        expect_at(1, S_PU2, 0, "mid_rst_pulse");
        tick(1);
        reset = 1'b1;
        tick(3);

        for (int i = 0; i < 50 && chk_q.size() > 0; i++) tick(1);
        check("pending_checks", chk_q.size(), 0);
        check("p1_pulse_count", p1_pulses, exp_p1_pulses);
        check("p2_pulse_count", p2_pulses, exp_p2_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
